// File: rtl/k16_bus_pkg.sv
// K16 bus package: frame-buffer window, CPU-side arbiter FSM states and the
// I/O register map shared with the CPU address decoder.
package k16_bus_pkg;

    localparam logic [15:0] FB_BASE = 16'h8000;   // CPU address of frame-buffer word 0
    localparam int          FB_SIZE = 1200;       // 40x30 text cells

    typedef enum logic [1:0] {
        CPU_IDLE    = 2'd0,
        CPU_RD_WAIT = 2'd1,
        CPU_ACK     = 2'd2
    } cpu_state_e;

    // I/O registers at the top of the CPU address space
    localparam logic [15:0] IO_UART_DATA = 16'hFFF8;
    localparam logic [15:0] IO_UART_STAT = 16'hFFF9;
    localparam logic [15:0] IO_TIMER_LO  = 16'hFFFA;
    localparam logic [15:0] IO_TIMER_HI  = 16'hFFFB;
    localparam logic [15:0] IO_LED       = 16'hFFFC;
    localparam logic [15:0] IO_SWITCH    = 16'hFFFD;
    localparam logic [15:0] IO_VGA_CTRL  = 16'hFFFE;

endpackage

// File: rtl/k16_fb_arbiter.sv
// Frame-buffer arbiter: shares the registered-read frame-buffer RAM between
// the VGA text fetcher (priority) and the CPU data bus (bounded starvation).
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   cpu_req/we/addr/wdata           CPU four-phase request
//   cpu_ack/rdata                   CPU completion and read data
//   vga_req/addr                    single-cycle VGA fetch strobe
//   vga_valid/data                  VGA fetch result (data = ram_dout)
//   ram_we/waddr/din                registered RAM write port
//   ram_raddr                       combinational RAM read address
//   ram_dout                        RAM read data, one cycle after ram_raddr
//
// CPU FSM states:
//   state       | meaning
//   ------------+---------------------------------------------------------
//   CPU_IDLE    | waiting for cpu_req; writes/misses finish here in one cycle
//   CPU_RD_WAIT | read slot granted, RAM data arrives this cycle
//   CPU_ACK     | cpu_ack high until cpu_req drops
module k16_fb_arbiter
    import k16_bus_pkg::*;
#(
    parameter int          ADDR_WIDTH   = 11,
    parameter int          DATA_WIDTH   = 16,
    parameter logic [15:0] FB_BASE      = k16_bus_pkg::FB_BASE,
    parameter int          FB_SIZE      = k16_bus_pkg::FB_SIZE,
    parameter int          STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [15:0]           cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_ack,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    input  logic                  vga_req,
    input  logic [ADDR_WIDTH-1:0] vga_addr,
    output logic                  vga_valid,
    output logic [DATA_WIDTH-1:0] vga_data,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_waddr,
    output logic [DATA_WIDTH-1:0] ram_din,
    output logic [ADDR_WIDTH-1:0] ram_raddr,
    input  logic [DATA_WIDTH-1:0] ram_dout
);

    localparam int          STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [16:0] WIN_LO   = {1'b0, FB_BASE};
    localparam logic [16:0] WIN_HI   = WIN_LO + 17'(FB_SIZE);

    cpu_state_e            state_q, state_d;
    logic [STARVE_W-1:0]   starve_q, starve_d;
    logic                  vga_pend;
    logic [ADDR_WIDTH-1:0] vga_pend_addr;

    logic                  fb_hit;
    logic [ADDR_WIDTH-1:0] cpu_offset;
    logic                  vga_any;
    logic                  starve_full;
    logic                  cpu_grant;
    logic                  wr_hit;
    logic                  rd_miss;
    logic                  vga_owns;

    // 17-bit compare so the window end may reach 0x10000 without wrapping
    assign fb_hit      = ({1'b0, cpu_addr} >= WIN_LO) && ({1'b0, cpu_addr} < WIN_HI);
    assign cpu_offset  = ADDR_WIDTH'(cpu_addr - FB_BASE);
    assign vga_any     = vga_req | vga_pend;
    assign starve_full = (starve_q == STARVE_W'(STARVE_LIMIT));

    always_comb begin
        state_d   = state_q;
        starve_d  = starve_q;
        cpu_grant = 1'b0;
        wr_hit    = 1'b0;
        rd_miss   = 1'b0;
        case (state_q)
            CPU_IDLE: begin
                if (cpu_req) begin
                    if (cpu_we) begin
                        wr_hit  = fb_hit;
                        state_d = CPU_ACK;
                    end else if (!fb_hit) begin
                        rd_miss = 1'b1;
                        state_d = CPU_ACK;
                    end else if (!vga_any || starve_full) begin
                        cpu_grant = 1'b1;
                        state_d   = CPU_RD_WAIT;
                    end else begin
                        // a full counter always wins the slot, so this never wraps
                        starve_d = starve_q + STARVE_W'(1);
                    end
                end
            end
            CPU_RD_WAIT: state_d = CPU_ACK;
            CPU_ACK:     if (!cpu_req) state_d = CPU_IDLE;
            default:     state_d = CPU_IDLE;
        endcase
        if (state_d == CPU_ACK && state_q != CPU_ACK) begin
            starve_d = '0;
        end
    end

    // A pending VGA fetch can only exist the cycle after a forced CPU slot,
    // when the CPU sits in RD_WAIT, so it is always served immediately.
    assign vga_owns  = vga_any & ~cpu_grant;
    assign ram_raddr = cpu_grant ? cpu_offset : (vga_pend ? vga_pend_addr : vga_addr);
    assign cpu_ack   = (state_q == CPU_ACK);
    assign vga_data  = ram_dout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= CPU_IDLE;
            starve_q      <= '0;
            cpu_rdata     <= '0;
            vga_valid     <= 1'b0;
            ram_we        <= 1'b0;
            ram_waddr     <= '0;
            ram_din       <= '0;
            vga_pend      <= 1'b0;
            vga_pend_addr <= '0;
        end else begin
            state_q   <= state_d;
            starve_q  <= starve_d;
            vga_valid <= vga_owns;
            ram_we    <= wr_hit;
            if (wr_hit) begin
                ram_waddr <= cpu_offset;
                ram_din   <= cpu_wdata;
            end
            if (rd_miss) begin
                cpu_rdata <= '0;
            end else if (state_q == CPU_RD_WAIT) begin
                cpu_rdata <= ram_dout;
            end
            vga_pend <= cpu_grant & vga_req;
            if (cpu_grant && vga_req) begin
                vga_pend_addr <= vga_addr;
            end
        end
    end

endmodule

// File: tb/tb_k16_fb_arbiter.sv
// Self-checking bench for k16_fb_arbiter: behavioural RAM, shadow-memory
// reference model, directed table, hand-written corner sequences and
// randomized CPU/VGA traffic.
module tb_k16_fb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req, cpu_we;
    logic [15:0] cpu_addr, cpu_wdata;
    logic        cpu_ack;
    logic [15:0] cpu_rdata;
    logic        vga_req;
    logic [10:0] vga_addr;
    logic        vga_valid;
    logic [15:0] vga_data;
    logic        ram_we;
    logic [10:0] ram_waddr;
    logic [15:0] ram_din;
    logic [10:0] ram_raddr;
    logic [15:0] ram_dout;

    k16_fb_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .vga_req(vga_req), .vga_addr(vga_addr), .vga_valid(vga_valid), .vga_data(vga_data),
        .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_din(ram_din),
        .ram_raddr(ram_raddr), .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] pat(input int a);
        return 16'(a * 37) ^ 16'h4C00;
    endfunction

    // frame-buffer RAM: registered read, read-before-write
    logic [15:0] mem [2048];
    bit          written [2048];
    always @(posedge clk) begin
        if (ram_we) begin
            mem[ram_waddr]     <= ram_din;
            written[ram_waddr] <= 1'b1;
        end
        ram_dout <= written[ram_raddr] ? mem[ram_raddr] : pat(int'(ram_raddr));
    end

    // reference model state
    logic [15:0] shadow [2048];
    int errors = 0;
    int checks = 0;
    int displaced = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic void check_range(input string name, input int v, input int lo, input int hi);
        checks++;
        if (v < lo || v > hi) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, v, lo, hi);
        end
    endfunction

    function automatic bit model_hit(input logic [15:0] a);
        return (int'(a) >= 32'h8000) && (int'(a) < 32'h8000 + 1200);
    endfunction

    function automatic int model_off(input logic [15:0] a);
        return int'(a) - 32'h8000;
    endfunction

    typedef struct {
        bit          we;
        logic [15:0] addr;
        logic [15:0] wdata;
        int          lat;
        logic [15:0] rdata;
        int          we_cnt;
        logic [10:0] off;
        bit          hit;
    } vec_t;
    vec_t vecs [11];

    typedef struct { int c; logic [10:0] a; } vreq_t;
    vreq_t vq [$];

    bit          mon_en = 1'b0;
    int          vga_mode = 0;   // 0 manual/idle, 1 every 2nd cycle, 2 random legal
    logic [15:0] bnd [4] = '{16'h7FFF, 16'h8000, 16'h84AF, 16'h84B0};

    int          lat, we_cnt;
    logic [15:0] rd, din;
    logic [10:0] wa, ra0;
    bit          held, rel;

    task automatic cpu_txn(input bit we, input logic [15:0] addr, input logic [15:0] wdata,
                           output int o_lat, output logic [15:0] o_rdata, output int o_we_cnt,
                           output logic [10:0] o_waddr, output logic [15:0] o_din,
                           output logic [10:0] o_raddr0, output bit o_held, output bit o_rel);
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        @(negedge clk);
        o_raddr0 = ram_raddr;
        o_lat = 0; o_we_cnt = 0; o_waddr = '0; o_din = '0;
        while (!cpu_ack && o_lat < 20) begin
            @(negedge clk);
            o_lat++;
            if (ram_we) begin o_we_cnt++; o_waddr = ram_waddr; o_din = ram_din; end
        end
        o_rdata = cpu_rdata;
        @(negedge clk);
        o_held = cpu_ack;
        if (ram_we) o_we_cnt++;
        @(posedge clk); #1;
        cpu_req = 1'b0;
        @(negedge clk);
        if (ram_we) o_we_cnt++;
        @(negedge clk);
        o_rel = !cpu_ack;
        if (ram_we) o_we_cnt++;
    endtask

    initial begin
        int d0;
        int n;
        logic [15:0] a, w;
        bit          we_r;

        rst_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        vga_req = 1'b0; vga_addr = '0;
        for (int i = 0; i < 2048; i++) shadow[i] = pat(i);

        vecs[0]  = '{1'b1, 16'h8005, 16'h3C41, 1, 16'h0000, 1, 11'h005, 1'b1};
        vecs[1]  = '{1'b0, 16'h8005, 16'h0000, 2, 16'h3C41, 0, 11'h005, 1'b1};
        vecs[2]  = '{1'b0, 16'h9000, 16'h0000, 1, 16'h0000, 0, 11'h000, 1'b0};
        vecs[3]  = '{1'b1, 16'h84B0, 16'h1234, 1, 16'h0000, 0, 11'h000, 1'b0};
        vecs[4]  = '{1'b0, 16'h84AF, 16'h0000, 2, pat(32'h4AF), 0, 11'h4AF, 1'b1};
        vecs[5]  = '{1'b1, 16'h84AF, 16'hBEEF, 1, 16'h0000, 1, 11'h4AF, 1'b1};
        vecs[6]  = '{1'b0, 16'h84AF, 16'h0000, 2, 16'hBEEF, 0, 11'h4AF, 1'b1};
        vecs[7]  = '{1'b0, 16'h7FFF, 16'h0000, 1, 16'h0000, 0, 11'h000, 1'b0};
        vecs[8]  = '{1'b1, 16'h8000, 16'hA5A5, 1, 16'h0000, 1, 11'h000, 1'b1};
        vecs[9]  = '{1'b0, 16'h8000, 16'h0000, 2, 16'hA5A5, 0, 11'h000, 1'b1};
        vecs[10] = '{1'b1, 16'h8030, 16'h8C57, 1, 16'h0000, 1, 11'h030, 1'b1};

        fork
            begin : vga_monitor
                forever begin
                    vreq_t e;
                    int    vl;
                    @(negedge clk);
                    if (!mon_en) begin
                        vq.delete();
                    end else begin
                        if (vga_valid) begin
                            if (vq.size() == 0) begin
                                check("vga_spurious_valid", 32'(vga_valid), 32'd0);
                            end else begin
                                e  = vq.pop_front();
                                vl = cyc - e.c;
                                if (vl == 2) displaced++;
                                check_range("vga_latency", vl, 1, 2);
                                check("vga_data", 32'(vga_data), 32'(shadow[e.a]));
                            end
                        end
                        if (vq.size() > 0 && cyc - vq[0].c > 2) begin
                            check_range("vga_timeout", cyc - vq[0].c, 1, 2);
                            void'(vq.pop_front());
                        end
                        if (vga_req) vq.push_back('{cyc, vga_addr});
                    end
                end
            end
            begin : vga_driver
                bit last = 1'b0;
                forever begin
                    @(posedge clk); #1;
                    if (vga_mode == 0) begin
                        if (last) begin vga_req = 1'b0; last = 1'b0; end
                    end else if (last) begin
                        vga_req = 1'b0; last = 1'b0;
                    end else if (vga_mode == 1 || $urandom_range(0, 2) != 0) begin
                        vga_req = 1'b1; vga_addr = 11'(1200 + $urandom_range(0, 847)); last = 1'b1;
                    end else begin
                        vga_req = 1'b0;
                    end
                end
            end
            begin : watchdog
                #500000;
                $display("FAIL watchdog: time limit reached");
                $fatal(1, "watchdog");
            end
        join_none

        // reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cpu_ack", 32'(cpu_ack), 32'd0);
        check("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
        check("rst_vga_valid", 32'(vga_valid), 32'd0);
        check("rst_ram_we", 32'(ram_we), 32'd0);
        check("rst_ram_waddr", 32'(ram_waddr), 32'd0);
        check("rst_ram_din", 32'(ram_din), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        mon_en = 1'b1;

        // directed table, VGA idle
        for (int i = 0; i < 11; i++) begin
            cpu_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, lat, rd, we_cnt, wa, din, ra0, held, rel);
            check($sformatf("tbl%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            check($sformatf("tbl%0d_ram_we_cycles", i), 32'(we_cnt), 32'(vecs[i].we_cnt));
            check($sformatf("tbl%0d_ack_held", i), 32'(held), 32'd1);
            check($sformatf("tbl%0d_ack_release", i), 32'(rel), 32'd1);
            if (vecs[i].we && vecs[i].hit) begin
                check($sformatf("tbl%0d_ram_waddr", i), 32'(wa), 32'(vecs[i].off));
                check($sformatf("tbl%0d_ram_din", i), 32'(din), 32'(vecs[i].wdata));
                shadow[vecs[i].off] = vecs[i].wdata;
            end
            if (!vecs[i].we) check($sformatf("tbl%0d_rdata", i), 32'(rd), 32'(vecs[i].rdata));
            if (!vecs[i].we && vecs[i].hit) check($sformatf("tbl%0d_ram_raddr", i), 32'(ra0), 32'(vecs[i].off));
        end

        // single VGA fetch of a CPU-written word
        @(posedge clk); #1;
        vga_req = 1'b1; vga_addr = 11'h030;
        @(negedge clk);
        check("vga030_raddr", 32'(ram_raddr), 32'h030);
        @(posedge clk); #1;
        vga_req = 1'b0;
        @(negedge clk);
        check("vga030_valid", 32'(vga_valid), 32'd1);
        check("vga030_data", 32'(vga_data), 32'h8C57);
        repeat (2) @(posedge clk);

        // legal VGA traffic every 2nd cycle plus CPU reads
        vga_mode = 1;
        for (int i = 0; i < 3; i++) begin
            cpu_txn(1'b0, 16'h8005, 16'h0, lat, rd, we_cnt, wa, din, ra0, held, rel);
            check_range("dense_latency", lat, 2, 6);
            check("dense_rdata", 32'(rd), 32'h3C41);
        end
        vga_mode = 0;
        repeat (3) @(posedge clk);

        // back-to-back VGA strobes starve the CPU until the slot is forced
        d0 = displaced;
        fork
            cpu_txn(1'b0, 16'h8005, 16'h0, lat, rd, we_cnt, wa, din, ra0, held, rel);
            begin
                @(posedge clk); #1;
                for (int i = 0; i < 5; i++) begin
                    vga_req = 1'b1; vga_addr = 11'(1300 + i * 7);
                    @(posedge clk); #1;
                end
                vga_req = 1'b0;
            end
        join
        check("forced_latency", 32'(lat), 32'd6);
        check("forced_rdata", 32'(rd), 32'h3C41);
        repeat (3) @(posedge clk);
        check("forced_vga_displaced", 32'(displaced - d0), 32'd1);

        // reset while a read is in RD_WAIT
        @(posedge clk); #1;
        mon_en = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h8005;
        @(posedge clk); #1;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rdwait_rst_ack", 32'(cpu_ack), 32'd0);
        check("rdwait_rst_rdata", 32'(cpu_rdata), 32'd0);
        check("rdwait_rst_vga_valid", 32'(vga_valid), 32'd0);
        cpu_req = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        mon_en = 1'b1;
        cpu_txn(1'b0, 16'h8005, 16'h0, lat, rd, we_cnt, wa, din, ra0, held, rel);
        check("post_rst_latency", 32'(lat), 32'd2);
        check("post_rst_rdata", 32'(rd), 32'h3C41);

        // reset before a write is taken: nothing must reach the RAM
        @(posedge clk); #1;
        mon_en = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h8010; cpu_wdata = 16'hDEAD;
        #3;
        rst_n = 1'b0;
        @(posedge clk); #1;
        cpu_req = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        mon_en = 1'b1;
        n = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (ram_we) n++;
        end
        check("aborted_write_ram_we", 32'(n), 32'd0);
        cpu_txn(1'b0, 16'h8010, 16'h0, lat, rd, we_cnt, wa, din, ra0, held, rel);
        check("aborted_write_rdata", 32'(rd), 32'(pat(32'h010)));

        // randomized CPU traffic against random legal VGA traffic
        vga_mode = 2;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0, 1:    a = 16'(32'h8000 + $urandom_range(0, 1199));
                2:       a = bnd[$urandom_range(0, 3)];
                default: a = 16'($urandom);
            endcase
            w    = 16'($urandom);
            we_r = 1'($urandom_range(0, 1));
            cpu_txn(we_r, a, w, lat, rd, we_cnt, wa, din, ra0, held, rel);
            check("rnd_ack_release", 32'(rel), 32'd1);
            if (we_r) begin
                check("rnd_wr_latency", 32'(lat), 32'd1);
                check("rnd_wr_ram_we", 32'(we_cnt), 32'(model_hit(a)));
                if (model_hit(a)) begin
                    check("rnd_wr_waddr", 32'(wa), 32'(model_off(a)));
                    check("rnd_wr_din", 32'(din), 32'(w));
                    shadow[model_off(a)] = w;
                end
            end else if (model_hit(a)) begin
                check_range("rnd_rd_latency", lat, 2, 6);
                check("rnd_rd_data", 32'(rd), 32'(shadow[model_off(a)]));
            end else begin
                check("rnd_miss_latency", 32'(lat), 32'd1);
                check("rnd_miss_data", 32'(rd), 32'd0);
            end
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        vga_mode = 0;
        repeat (4) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/k16_fb_arbiter.md
# k16_fb_arbiter

Shares the K16 frame-buffer dual-port RAM (2048x16, registered read port) between the VGA text-fetch engine and the K16 CPU data bus. Owns the RAM's write port (CPU writes only) and multiplexes its single read port between VGA character fetches and CPU readback. VGA has priority, with a bounded-starvation guarantee for the CPU. Sits between the CPU address decoder and the frame-buffer RAM in the top level.

## Interface
- `ADDR_WIDTH`, 11: RAM address width.
- `DATA_WIDTH`, 16: word width ({attr[7:0], char[7:0]}).
- `FB_BASE`, 16'h8000: CPU address of frame-buffer word 0.
- `FB_SIZE`, 1200: valid words (40x30).
- `STARVE_LIMIT`, 4: consecutive CPU-read stall cycles before the CPU is forced a read slot.

- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous active-low reset.
- `cpu_req` in 1: CPU transaction request, held until `cpu_ack`.
- `cpu_we` in 1: 1 = write, 0 = read; stable while `cpu_req`.
- `cpu_addr` in 16: CPU byte-less word address.
- `cpu_wdata` in 16: write data.
- `cpu_ack` out 1: transaction complete; held while `cpu_req` is high.
- `cpu_rdata` out 16: read data, valid while `cpu_ack`.
- `vga_req` in 1: single-cycle fetch strobe; min spacing 2 cycles.
- `vga_addr` in ADDR_WIDTH: fetch address.
- `vga_valid` out 1: one-cycle pulse, `vga_data` valid.
- `vga_data` out 16: passthrough of `ram_dout`.
- `ram_we` out 1, `ram_waddr` out ADDR_WIDTH, `ram_din` out 16: RAM write port (registered).
- `ram_raddr` out ADDR_WIDTH: RAM read address (combinational mux).
- `ram_dout` in 16: RAM read data, 1 cycle after `ram_raddr`.

## Operation
- Window hit: `FB_BASE <= cpu_addr < FB_BASE+FB_SIZE`; offset = `cpu_addr - FB_BASE`, truncated to ADDR_WIDTH.
- CPU FSM states: IDLE, RD_WAIT, ACK (four-phase handshake).
- IDLE, `cpu_req` & write: if hit, register `ram_we=1`, `ram_waddr=offset`, `ram_din=cpu_wdata` for one cycle; miss writes nothing. Either way -> ACK. Writes never wait on VGA.
- IDLE, `cpu_req` & read & miss: `cpu_rdata <= 0`, -> ACK.
- IDLE, `cpu_req` & read & hit: granted read slot if no VGA read this cycle, or starve counter == STARVE_LIMIT. Granted -> `ram_raddr=offset`, -> RD_WAIT. Not granted -> stay, starve counter +1 (saturating).
- RD_WAIT: `cpu_rdata <= ram_dout`, -> ACK.
- ACK: `cpu_ack=1`; -> IDLE when `cpu_req` low. Starve counter clears on entry.
- VGA read slot: `vga_req` or pending VGA request, unless the CPU is forced. Forced CPU slot with `vga_req` high sets `vga_pend` (latched addr), served next cycle.
- `vga_valid` registered: high the cycle after VGA owns `ram_raddr`.
- Same-cycle CPU write and VGA read of the same word: VGA may return old data.

## Timing
- Reset values: `cpu_ack=0`, `cpu_rdata=0`, `vga_valid=0`, `ram_we=0`, `ram_waddr=0`, `ram_din=0`, FSM=IDLE, starve=0, `vga_pend=0`. Reset mid-transaction aborts it; no write issued afterwards.
- CPU write: `cpu_req` at N -> `ram_we` at N+1, `cpu_ack` at N+1.
- CPU read, no contention: req N -> `cpu_ack` N+2, `cpu_rdata` valid N+2.
- CPU read worst case: N+2+STARVE_LIMIT.
- VGA fetch: `vga_req` N -> `vga_valid` N+1; deferred by forced CPU slot -> N+2 (never later).
- `ram_raddr` defaults to VGA address when no owner.

## Structure
- Package `k16_bus_pkg`: `FB_BASE`, `FB_SIZE`, CPU FSM state enum, I/O address constants (0xFFF8-0xFFFE).
- Single flat module; no sub-module.

## Test plan
- Write 0x8005 data 0x3C41, no VGA -> `ram_we` one cycle, `ram_waddr=5`, `ram_din=0x3C41`, `cpu_ack` at N+1.
- Read 0x8005 after that write, idle VGA -> `ram_raddr=5` at N, `cpu_rdata=0x3C41`, `cpu_ack` at N+2, held until `cpu_req` drops.
- Read 0x9000 (outside window) -> `cpu_rdata=0`, no RAM read, `cpu_ack` at N+1; write 0x84B0 -> no `ram_we`.
- `vga_req` every 2nd cycle plus CPU read -> CPU ack within N+2+4; displaced `vga_req` yields `vga_valid` at N+2 with correct word.
- `vga_req` addr 0x030 with RAM preloaded 0x8C57 -> `vga_valid` next cycle, `vga_data=0x8C57`.
- Assert `rst_n=0` in RD_WAIT -> `cpu_ack=0`, `vga_valid=0`, FSM IDLE; new read after reset completes normally.
